// File: rtl/dotmatrix_scan.sv
// rtl/dotmatrix_scan.sv - 16x16 dot-matrix row scanner with per-row glyph fetch.
// Optional DOTMATRIX_BLANK_PHASE_EN adds a blank (select 0) phase to the glyph rotation.
module dotmatrix_scan #(
  parameter int DWELL            = 64,
  parameter int FRAMES_PER_GLYPH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        word,
  output logic [3:0]  row,
  output logic [3:0]  col,
  output logic [1:0]  select,
  output logic [15:0] led_row,
  output logic [15:0] led_col,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAMES_PER_GLYPH - 1);

  state_t      state;
  logic [15:0] shadow;
  logic [15:0] shadow_next;
  logic [15:0] dwell_cnt;
  logic [15:0] frame_cnt;

  function automatic logic [1:0] next_select(input logic [1:0] s);
`ifdef DOTMATRIX_BLANK_PHASE_EN
    case (s)
      2'd1:    return 2'd2;
      2'd2:    return 2'd0;
      default: return 2'd1;
    endcase
`else
    return (s == 2'd1) ? 2'd2 : 2'd1;
`endif
  endfunction

  // Merging the current pixel lets the last column land in led_col on the same edge.
  always_comb begin
    shadow_next = shadow;
    shadow_next[4'd15 - col] = word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= 4'd0;
      col        <= 4'd0;
      select     <= 2'd1;
      led_row    <= 16'd0;
      led_col    <= 16'd0;
      frame_done <= 1'b0;
      shadow     <= 16'd0;
      dwell_cnt  <= 16'd0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      if (state != IDLE && !enable) begin
        state     <= IDLE;
        row       <= 4'd0;
        col       <= 4'd0;
        led_row   <= 16'd0;
        led_col   <= 16'd0;
        shadow    <= 16'd0;
        dwell_cnt <= 16'd0;
      end else begin
        case (state)
          IDLE: begin
            if (enable) state <= FETCH;
          end
          FETCH: begin
            shadow <= shadow_next;
            if (col == 4'd15) begin
              led_col   <= shadow_next;
              led_row   <= 16'd1 << row;
              col       <= 4'd0;
              dwell_cnt <= 16'd0;
              state     <= SHOW;
            end else begin
              col <= col + 4'd1;
            end
          end
          SHOW: begin
            if (dwell_cnt == DWELL_LAST) begin
              led_row <= 16'd0;
              row     <= row + 4'd1;
              state   <= FETCH;
              if (row == 4'd15) begin
                frame_done <= 1'b1;
                if (frame_cnt == FRAME_LAST) begin
                  frame_cnt <= 16'd0;
                  select    <= next_select(select);
                end else begin
                  frame_cnt <= frame_cnt + 16'd1;
                end
              end
            end else begin
              dwell_cnt <= dwell_cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dotmatrix_scan.sv
// tb/tb_dotmatrix_scan.sv - self-checking bench for dotmatrix_scan (two parameter sets).
// Honours DOTMATRIX_BLANK_PHASE_EN when the macro is defined for the build.
module tb_dotmatrix_scan;

  localparam int D0 = 4;
  localparam int F0 = 2;
  localparam int D1 = 1;
  localparam int F1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        word_d [2];
  logic [3:0]  row_d [2];
  logic [3:0]  col_d [2];
  logic [1:0]  sel_d [2];
  logic [15:0] led_row_d [2];
  logic [15:0] led_col_d [2];
  logic        fd_d [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dotmatrix_scan #(.DWELL(D0), .FRAMES_PER_GLYPH(F0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .word(word_d[0]),
    .row(row_d[0]), .col(col_d[0]), .select(sel_d[0]),
    .led_row(led_row_d[0]), .led_col(led_col_d[0]), .frame_done(fd_d[0])
  );

  dotmatrix_scan #(.DWELL(D1), .FRAMES_PER_GLYPH(F1)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .word(word_d[1]),
    .row(row_d[1]), .col(col_d[1]), .select(sel_d[1]),
    .led_row(led_row_d[1]), .led_col(led_col_d[1]), .frame_done(fd_d[1])
  );

  // Glyph bitmaps in led_col orientation (bit 15 = column 0).
  function automatic logic [15:0] glyph(input int sel, input int r);
    logic [15:0] g;
    g = 16'h0000;
    if (sel == 1) begin
      if (r == 2 || r == 13) g = 16'h0FF0;
      else if (r >= 3 && r <= 12) g = 16'h1008;
    end else if (sel == 2) begin
      for (int c = 0; c < 16; c++)
        if ((c >= r - 1 && c <= r + 1) || (c >= 14 - r && c <= 16 - r)) g[15 - c] = 1'b1;
    end
    return g;
  endfunction

  always_comb begin
    logic [15:0] g0;
    logic [15:0] g1;
    g0 = glyph(int'(sel_d[0]), int'(row_d[0]));
    g1 = glyph(int'(sel_d[1]), int'(row_d[1]));
    word_d[0] = g0[4'd15 - col_d[0]];
    word_d[1] = g1[4'd15 - col_d[1]];
  end

  function automatic int sel_model(input int frames, input int fpg);
    int k;
    k = frames / fpg;
`ifdef DOTMATRIX_BLANK_PHASE_EN
    case (k % 3)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
`else
    return (k % 2 == 0) ? 1 : 2;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: running flag, cycle index since first FETCH, frames completed before this run.
  bit valid_m = 1'b0;
  bit run_m [2];
  int t_m [2];
  int fb_m [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int fr;
      fr = 16 * (16 + ((i == 0) ? D0 : D1));
      if (rst) begin
        run_m[i] = 1'b0;
        t_m[i] = 0;
        fb_m[i] = 0;
      end else if (valid_m) begin
        if (run_m[i]) begin
          if (!enable) begin
            fb_m[i] = fb_m[i] + t_m[i] / fr;
            run_m[i] = 1'b0;
          end else begin
            t_m[i] = t_m[i] + 1;
          end
        end else if (enable) begin
          run_m[i] = 1'b1;
          t_m[i] = 0;
        end
      end
    end
    if (rst) valid_m = 1'b1;
  end

  always @(negedge clk) begin
    if (valid_m) begin
      for (int i = 0; i < 2; i++) begin
        int p, fr, fpg, t, r, ph, e_sel, e_row, e_col, e_fd;
        logic [15:0] e_lr, e_lc;
        p = 16 + ((i == 0) ? D0 : D1);
        fr = 16 * p;
        fpg = (i == 0) ? F0 : F1;
        t = t_m[i];
        if (!run_m[i]) begin
          e_sel = sel_model(fb_m[i], fpg);
          e_row = 0; e_col = 0; e_fd = 0;
          e_lr = 16'h0; e_lc = 16'h0;
        end else begin
          r = (t / p) % 16;
          ph = t % p;
          e_sel = sel_model(fb_m[i] + t / fr, fpg);
          e_row = r;
          e_fd = (t > 0 && t % fr == 0) ? 1 : 0;
          if (ph < 16) begin
            e_col = ph;
            e_lr = 16'h0;
            e_lc = (t < p) ? 16'h0 : glyph(sel_model(fb_m[i] + (t - p) / fr, fpg), ((t - p) / p) % 16);
          end else begin
            e_col = 0;
            e_lr = 16'(1 << r);
            e_lc = glyph(e_sel, r);
          end
        end
        check($sformatf("u%0d.row", i), 32'(row_d[i]), 32'(e_row));
        check($sformatf("u%0d.col", i), 32'(col_d[i]), 32'(e_col));
        check($sformatf("u%0d.select", i), 32'(sel_d[i]), 32'(e_sel));
        check($sformatf("u%0d.led_row", i), 32'(led_row_d[i]), 32'(e_lr));
        check($sformatf("u%0d.led_col", i), 32'(led_col_d[i]), 32'(e_lc));
        check($sformatf("u%0d.frame_done", i), 32'(fd_d[i]), 32'(e_fd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_t(input int target);
    int guard;
    guard = 0;
    while ((!run_m[0] || t_m[0] < target) && guard < 5000) begin
      tick();
      guard++;
    end
    if (guard >= 5000) check("wait_t_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int guard;
    repeat (3) tick();
    rst = 1'b0;
    check("rst.led_row", 32'(led_row_d[0]), 32'h0);
    check("rst.led_col", 32'(led_col_d[0]), 32'h0);
    check("rst.select", 32'(sel_d[0]), 32'd1);
    check("rst.frame_done", 32'(fd_d[0]), 32'd0);
    tick();
    enable = 1'b1;
    tick();
    check("t0.col", 32'(col_d[0]), 32'd0);
    check("t0.led_row", 32'(led_row_d[0]), 32'h0);
    wait_t(16);
    check("t16.led_row", 32'(led_row_d[0]), 32'h0001);
    check("t16.led_col", 32'(led_col_d[0]), 32'h0000);
    wait_t(56);
    check("row2.led_row", 32'(led_row_d[0]), 32'h0004);
    check("row2.led_col", 32'(led_col_d[0]), 32'h0FF0);
    wait_t(319);
    check("t319.frame_done", 32'(fd_d[0]), 32'd0);
    tick();
    check("t320.frame_done", 32'(fd_d[0]), 32'd1);
    check("t320.select", 32'(sel_d[0]), 32'd1);
    check("fpg1.select", 32'(sel_d[1]), 32'd2);
    wait_t(639);
    check("t639.select", 32'(sel_d[0]), 32'd1);
    tick();
    check("t640.frame_done", 32'(fd_d[0]), 32'd1);
    check("t640.select", 32'(sel_d[0]), 32'd2);
    wait_t(676);
    check("x.row1.led_row", 32'(led_row_d[0]), 32'h0002);
    check("x.row1.led_col", 32'(led_col_d[0]), 32'hE007);
    wait_t(1280);
`ifdef DOTMATRIX_BLANK_PHASE_EN
    check("t1280.select", 32'(sel_d[0]), 32'd0);
`else
    check("t1280.select", 32'(sel_d[0]), 32'd1);
`endif
    wait_t(1920);
    guard = 0;
    while (!(row_d[0] == 4'd5 && col_d[0] == 4'd7) && guard < 1000) begin
      tick();
      guard++;
    end
    if (guard >= 1000) check("row5col7_timeout", 32'd0, 32'd1);
    enable = 1'b0;
    tick();
    check("dis.led_row", 32'(led_row_d[0]), 32'h0);
    check("dis.led_col", 32'(led_col_d[0]), 32'h0);
    check("dis.row", 32'(row_d[0]), 32'd0);
    repeat (9) tick();
`ifdef DOTMATRIX_BLANK_PHASE_EN
    check("dis.select", 32'(sel_d[0]), 32'd1);
`else
    check("dis.select", 32'(sel_d[0]), 32'd2);
`endif
    enable = 1'b1;
    tick();
    check("reen.row", 32'(row_d[0]), 32'd0);
    check("reen.col", 32'(col_d[0]), 32'd0);
    guard = 0;
    while (led_row_d[0] == 16'h0 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("show_timeout", 32'd0, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("midrst.led_row", 32'(led_row_d[0]), 32'h0);
    check("midrst.led_col", 32'(led_col_d[0]), 32'h0);
    check("midrst.select", 32'(sel_d[0]), 32'd1);
    check("midrst.row", 32'(row_d[0]), 32'd0);
    rst = 1'b0;
    repeat (400) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
